// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser.
//   state_t           - parser FSM states
//   SYNC_BYTE_DEF     - default frame start marker
//   MAX_LEN_DEF       - default maximum payload length (power of 2, <= 256)
//   TIMEOUT_CLKS_DEF  - default inter-byte timeout (20 bit-times at 13158 clks/bit)
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hAA;
  localparam int         MAX_LEN_DEF      = 16;
  localparam int         TIMEOUT_CLKS_DEF = 263160;

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload store for the frame parser: DEPTH x 8 bits.
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the read register only
//   we      - write enable
//   wr_addr - write index
//   wr_data - write byte
//   rd_addr - read index, sampled on the clock edge
//   rd_data - registered read byte
module frame_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage is deliberately not reset so a held frame survives a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses UART byte frames of the form SYNC, LEN, LEN payload bytes, CHK where
// CHK is the XOR of LEN and every payload byte. A checked frame is held in
// the payload buffer until the consumer acknowledges it.
//   i_Clock       - sole clock, rising edge
//   i_Reset       - synchronous active-high reset
//   i_Rx_DV       - one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte     - received byte
//   o_Frame_Valid - a checked frame is held
//   i_Frame_Ack   - consumer releases the held frame
//   o_Frame_Len   - payload length of the held frame
//   i_Rd_Addr     - payload read index
//   o_Rd_Data     - registered payload byte at i_Rd_Addr
//   o_Chk_Err, o_Len_Err, o_Timeout, o_Overrun - one-cycle error pulses
//
// state     | meaning
// S_IDLE    | hunting for the sync byte, other bytes discarded
// S_LEN     | expecting the length byte
// S_PAYLOAD | storing payload bytes and accumulating the checksum
// S_CHECK   | expecting the checksum byte
// S_HOLD    | checked frame held until acknowledged
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_LEN      = MAX_LEN_DEF,
  parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Rx_DV,
  input  logic [7:0]                 i_Rx_Byte,
  output logic                       o_Frame_Valid,
  input  logic                       i_Frame_Ack,
  output logic [$clog2(MAX_LEN):0]   o_Frame_Len,
  input  logic [$clog2(MAX_LEN)-1:0] i_Rd_Addr,
  output logic [7:0]                 o_Rd_Data,
  output logic                       o_Chk_Err,
  output logic                       o_Len_Err,
  output logic                       o_Timeout,
  output logic                       o_Overrun
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);

  state_t          state_q, state_nx;
  logic [LW-1:0]   len_q;
  logic [AW-1:0]   idx_q;
  logic [7:0]      chk_q;
  logic [TW-1:0]   tmr_q;

  logic is_sync, len_ok, last_byte, counting, tmr_expire;
  logic buf_we, len_ld;
  logic chk_err_nx, len_err_nx, timeout_nx, overrun_nx;

  assign is_sync   = (i_Rx_Byte == SYNC_BYTE);
  assign len_ok    = (i_Rx_Byte != 8'd0) && ({1'b0, i_Rx_Byte} <= MAX_LEN_W);
  assign last_byte = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign counting  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmr_expire = counting && !i_Rx_DV && (tmr_q == '0);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && is_sync) state_nx = S_LEN;
      end
      S_LEN: begin
        if (i_Rx_DV)         state_nx = len_ok ? S_PAYLOAD : S_IDLE;
        else if (tmr_expire) state_nx = S_IDLE;
      end
      S_PAYLOAD: begin
        if (i_Rx_DV && last_byte) state_nx = S_CHECK;
        else if (tmr_expire)      state_nx = S_IDLE;
      end
      S_CHECK: begin
        if (i_Rx_DV)         state_nx = (i_Rx_Byte == chk_q) ? S_HOLD : S_IDLE;
        else if (tmr_expire) state_nx = S_IDLE;
      end
      S_HOLD: begin
        // On release, a coincident byte is handled as if already idle.
        if (i_Frame_Ack) state_nx = (i_Rx_DV && is_sync) ? S_LEN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    buf_we     = 1'b0;
    len_ld     = 1'b0;
    chk_err_nx = 1'b0;
    len_err_nx = 1'b0;
    timeout_nx = 1'b0;
    overrun_nx = 1'b0;
    case (state_q)
      S_LEN: begin
        if (i_Rx_DV) begin
          len_ld     = len_ok;
          len_err_nx = !len_ok;
        end else begin
          timeout_nx = tmr_expire;
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) buf_we     = 1'b1;
        else         timeout_nx = tmr_expire;
      end
      S_CHECK: begin
        if (i_Rx_DV) chk_err_nx = (i_Rx_Byte != chk_q);
        else         timeout_nx = tmr_expire;
      end
      S_HOLD: begin
        overrun_nx = i_Rx_DV && !i_Frame_Ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= 8'h00;
      tmr_q     <= '0;
      o_Chk_Err <= 1'b0;
      o_Len_Err <= 1'b0;
      o_Timeout <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      o_Chk_Err <= chk_err_nx;
      o_Len_Err <= len_err_nx;
      o_Timeout <= timeout_nx;
      o_Overrun <= overrun_nx;
      // Inter-byte timer: reloaded by every byte, terminal count at zero.
      if (i_Rx_DV) begin
        tmr_q <= TMR_LOAD;
      end else if (counting && (tmr_q != '0)) begin
        tmr_q <= tmr_q - TW'(1);
      end
      if (len_ld) begin
        len_q <= LW'(i_Rx_Byte);
        chk_q <= i_Rx_Byte;
        idx_q <= '0;
      end else if (buf_we) begin
        chk_q <= chk_q ^ i_Rx_Byte;
        idx_q <= idx_q + AW'(1);
      end
    end
  end

  assign o_Frame_Valid = (state_q == S_HOLD);
  assign o_Frame_Len   = len_q;

  frame_buf #(
    .DEPTH (MAX_LEN)
  ) u_frame_buf (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .we      (buf_we && !i_Reset),
    .wr_addr (idx_q),
    .wr_data (i_Rx_Byte),
    .rd_addr (i_Rd_Addr),
    .rd_data (o_Rd_Data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TO_CLKS = 64;
  localparam logic [7:0] SYNC    = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rx = 8'h00;
  logic       ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       valid;
  logic [4:0] flen;
  logic [7:0] rd_data;
  logic       chk_err, len_err, tmo, ovr;

  int checks = 0;
  int failures = 0;
  int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

  uart_frame_parser #(
    .SYNC_BYTE    (SYNC),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TO_CLKS)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (dv),
    .i_Rx_Byte     (rx),
    .o_Frame_Valid (valid),
    .i_Frame_Ack   (ack),
    .o_Frame_Len   (flen),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Data     (rd_data),
    .o_Chk_Err     (chk_err),
    .o_Len_Err     (len_err),
    .o_Timeout     (tmo),
    .o_Overrun     (ovr)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_err) n_chk++;
    if (len_err) n_len++;
    if (tmo)     n_to++;
    if (ovr)     n_ovr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    dv = 1'b1;
    rx = b;
    tick();
    dv = 1'b0;
    rx = 8'($urandom);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] pl[$]);
    logic [7:0] s = len;
    foreach (pl[i]) s ^= pl[i];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] chk);
    send_byte(SYNC);
    idle($urandom_range(0, 2));
    send_byte(len);
    foreach (pl[i]) begin
      idle($urandom_range(0, 2));
      send_byte(pl[i]);
    end
    idle($urandom_range(0, 2));
    send_byte(chk);
  endtask

  // Held frame must match pl exactly; then released with an ack.
  task automatic expect_frame(input string name, input logic [7:0] pl[$]);
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL %s valid: got %0b expected 1", name, valid);
    end
    checks++;
    if (flen !== 5'(pl.size())) begin
      failures++;
      $display("FAIL %s len: got %0d expected %0d", name, flen, pl.size());
    end
    foreach (pl[i]) begin
      rd_addr = 4'(i);
      tick();
      checks++;
      if (rd_data !== pl[i]) begin
        failures++;
        $display("FAIL %s data[%0d]: got %02h expected %02h", name, i, rd_data, pl[i]);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release: valid got %0b expected 0", name, valid);
    end
  endtask

  task automatic test_reset();
    int l0;
    rst = 1'b1;
    dv = 1'b1;
    rx = SYNC;
    idle(3);
    checks++;
    if ({valid, flen, rd_data, chk_err, len_err, tmo, ovr} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got v=%0b len=%0d rd=%02h pulses=%0b%0b%0b%0b expected all 0",
               valid, flen, rd_data, chk_err, len_err, tmo, ovr);
    end
    dv = 1'b0;
    rst = 1'b0;
    tick();
    // A sync byte seen during reset would turn the next AA into a bad LEN.
    l0 = n_len;
    send_frame(8'h01, '{8'h7E}, 8'h7F);
    checks++;
    if (n_len !== l0) begin
      failures++;
      $display("FAIL reset_rxdv_ignored: len_err pulses got %0d expected 0", n_len - l0);
    end
    expect_frame("reset_first_frame", '{8'h7E});
  endtask

  task automatic test_basic();
    send_frame(8'h03, '{8'h11, 8'h22, 8'h33}, 8'h03);
    expect_frame("basic", '{8'h11, 8'h22, 8'h33});
  endtask

  task automatic test_chk_err();
    int c0 = n_chk;
    logic [7:0] pl[$] = '{8'h5C, SYNC, 8'h01};
    send_frame(8'h02, '{8'h10, 8'h20}, 8'h31);
    checks++;
    if (chk_err !== 1'b1) begin
      failures++;
      $display("FAIL chk_err_timing: got %0b expected 1", chk_err);
    end
    idle(3);
    checks++;
    if (n_chk - c0 !== 1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL chk_err: pulses got %0d valid %0b expected 1 pulse valid 0", n_chk - c0, valid);
    end
    // Embedded sync byte is payload, not a resync.
    send_frame(8'h03, pl, xsum(8'h03, pl));
    expect_frame("after_chk_err", pl);
  endtask

  task automatic test_len_err();
    int l0 = n_len;
    logic [7:0] pl[$];
    send_byte(SYNC);
    send_byte(8'h00);
    checks++;
    if (len_err !== 1'b1) begin
      failures++;
      $display("FAIL len_err_zero: got %0b expected 1", len_err);
    end
    send_byte(SYNC);
    send_byte(8'h11);
    idle(2);
    checks++;
    if (n_len - l0 !== 2) begin
      failures++;
      $display("FAIL len_err_count: got %0d expected 2", n_len - l0);
    end
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
    send_frame(8'h10, pl, xsum(8'h10, pl));
    expect_frame("len_max", pl);
  endtask

  task automatic test_timeout();
    int t0 = n_to;
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h01);
    idle(TO_CLKS - 1);
    checks++;
    if (tmo !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got %0b expected 0", tmo);
    end
    tick();
    checks++;
    if (tmo !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: got %0b expected 1", tmo);
    end
    idle(3);
    checks++;
    if (n_to - t0 !== 1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_count: got %0d valid %0b expected 1 valid 0", n_to - t0, valid);
    end
    // Byte on the expiry cycle keeps the frame alive.
    t0 = n_to;
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h01);
    idle(TO_CLKS - 1);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h00);
    checks++;
    if (n_to !== t0) begin
      failures++;
      $display("FAIL timeout_suppressed: pulses got %0d expected 0", n_to - t0);
    end
    expect_frame("timeout_survivor", '{8'h01, 8'h02, 8'h03, 8'h04});
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] pl[$] = '{8'hC3, 8'h3C, 8'h99};
    send_frame(8'h03, pl, xsum(8'h03, pl));
    o0 = n_ovr;
    send_byte(8'h55);
    checks++;
    if (ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse: got %0b expected 1", ovr);
    end
    send_byte(SYNC);
    idle(2);
    checks++;
    if (n_ovr - o0 !== 2) begin
      failures++;
      $display("FAIL overrun_count: got %0d expected 2", n_ovr - o0);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      tick();
      checks++;
      if (rd_data !== pl[i]) begin
        failures++;
        $display("FAIL overrun_buffer[%0d]: got %02h expected %02h", i, rd_data, pl[i]);
      end
    end
    o0 = n_ovr;
    ack = 1'b1;
    send_byte(SYNC);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_with_sync release: valid got %0b expected 0", valid);
    end
    send_byte(8'h02);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hFD);
    checks++;
    if (n_ovr !== o0) begin
      failures++;
      $display("FAIL ack_with_sync overrun: got %0d expected 0", n_ovr - o0);
    end
    expect_frame("ack_with_sync", '{8'h5A, 8'hA5});
  endtask

  task automatic test_reset_mid();
    int p0 = n_chk + n_len + n_to + n_ovr;
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h11);
    rst = 1'b1;
    tick();
    checks++;
    if ({valid, flen, rd_data, chk_err, len_err, tmo, ovr} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs: got v=%0b len=%0d rd=%02h expected all 0", valid, flen, rd_data);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (n_chk + n_len + n_to + n_ovr !== p0) begin
      failures++;
      $display("FAIL reset_mid pulses: got %0d expected 0", n_chk + n_len + n_to + n_ovr - p0);
    end
    send_frame(8'h01, '{8'h7E}, 8'h7F);
    expect_frame("reset_mid_next", '{8'h7E});
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(0, 2);
      int len = $urandom_range(1, MAX_LEN);
      int c0 = n_chk, l0 = n_len;
      logic [7:0] pl[$];
      logic [7:0] b;
      for (int j = 0; j < $urandom_range(0, 3); j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h55;
        ack = $urandom_range(0, 1);
        send_byte(b);
        ack = 1'b0;
      end
      for (int j = 0; j < len; j++) pl.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
      if (kind == 2) begin
        send_byte(SYNC);
        b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
        send_byte(b);
        idle(2);
        checks++;
        if (n_len - l0 !== 1 || valid !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d len_err: pulses %0d valid %0b expected 1 and 0", f, n_len - l0, valid);
        end
      end else if (kind == 1) begin
        send_frame(8'(len), pl, xsum(8'(len), pl) ^ 8'($urandom_range(1, 255)));
        idle(2);
        checks++;
        if (n_chk - c0 !== 1 || valid !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d chk_err: pulses %0d valid %0b expected 1 and 0", f, n_chk - c0, valid);
        end
      end else begin
        send_frame(8'(len), pl, xsum(8'(len), pl));
        expect_frame($sformatf("rand%0d", f), pl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chk_err();
    test_len_err();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (power of 2, ≤256).
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 263160, inter-byte timeout in clocks (20 bit-times at 13158 clks/bit).
REQ-004 SHALL have port i_Clock, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port i_Reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_Rx_DV, input, 1, one-cycle strobe: i_Rx_Byte valid.
REQ-007 SHALL have port i_Rx_Byte, input, 8, received UART byte.
REQ-008 SHALL have port o_Frame_Valid, output, 1, level: a checked frame is held in the buffer.
REQ-009 SHALL have port i_Frame_Ack, input, 1, consumer releases the held frame.
REQ-010 SHALL have port o_Frame_Len, output, $clog2(MAX_LEN)+1, payload length of the held frame.
REQ-011 SHALL have port i_Rd_Addr, input, $clog2(MAX_LEN), payload read index.
REQ-012 SHALL have port o_Rd_Data, output, 8, payload byte at i_Rd_Addr.
REQ-013 SHALL have ports o_Chk_Err, o_Len_Err, o_Timeout, o_Overrun, output, 1 each, one-cycle error pulses.

Function
REQ-014 SHALL parse frames: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-015 SHALL implement states S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD.
REQ-016 S_IDLE: byte == SYNC_BYTE -> S_LEN; any other byte discarded silently.
REQ-017 S_LEN: LEN in 1..MAX_LEN -> store LEN, init checksum to LEN, index 0, -> S_PAYLOAD; LEN 0 or >MAX_LEN -> o_Len_Err pulse, -> S_IDLE.
REQ-018 S_PAYLOAD: each byte written to buffer[index], XORed into checksum, index++; after byte number LEN -> S_CHECK.
REQ-019 S_CHECK: byte == checksum -> S_HOLD, o_Frame_Valid high next cycle; mismatch -> o_Chk_Err pulse, -> S_IDLE.
REQ-020 S_HOLD: o_Frame_Valid and o_Frame_Len stable until i_Frame_Ack sampled high; then -> S_IDLE, o_Frame_Valid low next cycle.
REQ-021 S_HOLD: every incoming byte dropped with one o_Overrun pulse; buffer not modified.
REQ-022 Same-cycle i_Frame_Ack and i_Rx_DV in S_HOLD: ack honoured and byte processed as in S_IDLE (SYNC_BYTE -> S_LEN, no o_Overrun).
REQ-023 i_Frame_Ack outside S_HOLD SHALL be ignored.
REQ-024 Timeout counter SHALL clear on every i_Rx_DV and count in S_LEN, S_PAYLOAD, S_CHECK; reaching TIMEOUT_CLKS-1 -> o_Timeout pulse, -> S_IDLE.
REQ-025 i_Rx_DV in the cycle the timeout expires SHALL win: byte processed, no timeout.
REQ-026 o_Rd_Data SHALL be registered: data for i_Rd_Addr at edge N valid after edge N; addresses ≥ o_Frame_Len return stale contents, undefined.
REQ-027 Byte-to-state latency SHALL be one clock; error pulses assert in the cycle after the offending byte.
REQ-028 A new SYNC_BYTE inside S_LEN/S_PAYLOAD/S_CHECK SHALL be treated as data, not resync.

Reset
REQ-029 i_Reset SHALL put state in S_IDLE, clear counters, index, checksum, o_Frame_Valid, o_Frame_Len, o_Rd_Data and all error pulses to 0.
REQ-030 Reset mid-frame or in S_HOLD SHALL abandon the frame with no error pulse; buffer contents not reset.
REQ-031 i_Rx_DV during reset SHALL be ignored.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum and default SYNC_BYTE/MAX_LEN constants.
REQ-033 Payload storage SHALL be sub-module frame_buf: MAX_LEN x 8, synchronous write, registered read.

Verification
REQ-034 Send AA 03 11 22 33 03 -> o_Frame_Valid=1, o_Frame_Len=3, reads 0..2 return 11,22,33; ack -> Valid=0 next cycle.
REQ-035 Send AA 02 10 20 31 (expected 32) -> single o_Chk_Err pulse, o_Frame_Valid stays 0, next good frame accepted.
REQ-036 Send AA 00 and AA 11 (MAX_LEN=16) -> o_Len_Err pulse each; AA 10 + 16 bytes + correct CHK accepted.
REQ-037 Send AA 04 01, then idle TIMEOUT_CLKS clocks -> one o_Timeout pulse, state S_IDLE; byte arriving on expiry cycle suppresses timeout.
REQ-038 While holding frame send 55 -> o_Overrun pulse, buffer unchanged; ack coincident with AA -> frame released, new frame parsing started.
REQ-039 Assert i_Reset after AA 03 11 -> all outputs 0; then AA 01 7E 7F -> valid frame, Len=1, data 7E.
